// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encoding and the millisecond-to-clock-cycle conversion.
package btn_pkg;

   typedef logic [2:0] btn_state_t;

   localparam btn_state_t ST_RELEASED   = 3'd0;
   localparam btn_state_t ST_PRESS_DB   = 3'd1;
   localparam btn_state_t ST_PRESSED    = 3'd2;
   localparam btn_state_t ST_LONG_HELD  = 3'd3;
   localparam btn_state_t ST_RELEASE_DB = 3'd4;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; both stages
// reset to RST_VAL so an idle pin reads as idle straight out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next-state of the two synchroniser stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw board push-button and derives a clean level, short/long
// press strobes, a blink-enable toggle and a 2-bit mode counter.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int   CLK_HZ        = 20000000,
   parameter int   DEBOUNCE_MS   = 10,
   parameter int   LONG_PRESS_MS = 1000,
   parameter logic ACTIVE_LOW    = 1'b1
) (
   input  logic       clk_20Mhz,
   input  logic       rst,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       long_pulse,
   output logic       toggle_out,
   output logic [1:0] mode
);

   localparam int DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
   localparam int DB_W     = $clog2(DB_CYC);
   localparam int LONG_W   = $clog2(LONG_CYC);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

   logic pin_sync_s;
   logic s_pr;

   btn_state_t        state_q,       state_d;
   logic [DB_W-1:0]   db_cnt_q,      db_cnt_d;
   logic [LONG_W-1:0] hold_cnt_q,    hold_cnt_d;
   logic              long_flag_q,   long_flag_d;
   logic              btn_level_q,   btn_level_d;
   logic              press_pulse_q, press_pulse_d;
   logic              long_pulse_q,  long_pulse_d;
   logic              toggle_q,      toggle_d;
   logic [1:0]        mode_q,        mode_d;

   sync_2ff #(
      .RST_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk_20Mhz),
      .rst (rst),
      .d   (btn_in),
      .q   (pin_sync_s)
   );

   assign s_pr = pin_sync_s ^ ACTIVE_LOW;

   // Press/release debounce FSM with hold timing and output derivation.
   always_comb begin
      state_d       = state_q;
      db_cnt_d      = db_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      long_flag_d   = long_flag_q;
      btn_level_d   = btn_level_q;
      press_pulse_d = 1'b0;
      long_pulse_d  = 1'b0;
      toggle_d      = toggle_q;
      mode_d        = mode_q;

      case (state_q)
         ST_RELEASED: begin
            if (s_pr) begin
               state_d    = ST_PRESS_DB;
               db_cnt_d   = '0;
               hold_cnt_d = '0;
            end else begin
               state_d = ST_RELEASED;
            end
         end
         ST_PRESS_DB: begin
            if (!s_pr) begin
               state_d  = ST_RELEASED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               db_cnt_d    = '0;
               btn_level_d = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (hold_cnt_q != LONG_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
            // The long-press threshold takes priority over a simultaneous release.
            if (hold_cnt_q == LONG_LAST) begin
               state_d      = ST_LONG_HELD;
               db_cnt_d     = '0;
               long_pulse_d = 1'b1;
               mode_d       = mode_q + 2'd1;
               long_flag_d  = 1'b1;
            end else if (!s_pr) begin
               state_d     = ST_RELEASE_DB;
               db_cnt_d    = '0;
               long_flag_d = 1'b0;
            end else begin
               state_d = ST_PRESSED;
            end
         end
         ST_LONG_HELD: begin
            if (!s_pr) begin
               state_d  = ST_RELEASE_DB;
               db_cnt_d = '0;
            end else begin
               state_d = ST_LONG_HELD;
            end
         end
         ST_RELEASE_DB: begin
            // A re-press resumes the interrupted hold rather than restarting it.
            if (s_pr) begin
               state_d  = long_flag_q ? ST_LONG_HELD : ST_PRESSED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_RELEASED;
               db_cnt_d    = '0;
               btn_level_d = 1'b0;
               if (!long_flag_q) begin
                  press_pulse_d = 1'b1;
                  toggle_d      = ~toggle_q;
               end else begin
                  press_pulse_d = 1'b0;
               end
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = ST_RELEASED;
            db_cnt_d    = '0;
            hold_cnt_d  = '0;
            btn_level_d = 1'b0;
         end
      endcase
   end

   // FSM, counter and output registers.
   always_ff @(posedge clk_20Mhz or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RELEASED;
         db_cnt_q      <= '0;
         hold_cnt_q    <= '0;
         long_flag_q   <= 1'b0;
         btn_level_q   <= 1'b0;
         press_pulse_q <= 1'b0;
         long_pulse_q  <= 1'b0;
         toggle_q      <= 1'b0;
         mode_q        <= 2'd0;
      end else begin
         state_q       <= state_d;
         db_cnt_q      <= db_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         long_flag_q   <= long_flag_d;
         btn_level_q   <= btn_level_d;
         press_pulse_q <= press_pulse_d;
         long_pulse_q  <= long_pulse_d;
         toggle_q      <= toggle_d;
         mode_q        <= mode_d;
      end
   end

   assign btn_level   = btn_level_q;
   assign press_pulse = press_pulse_q;
   assign long_pulse  = long_pulse_q;
   assign toggle_out  = toggle_q;
   assign mode        = mode_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: each press pushes its expected output events (kind, cycle,
// toggle/mode after the event); a negedge monitor pops and compares them.
module tb_button_conditioner;
   import btn_pkg::*;

   localparam int DB   = 4;
   localparam int LONG = 20;

   localparam int EV_RISE  = 0;
   localparam int EV_FALL  = 1;
   localparam int EV_PRESS = 2;
   localparam int EV_LONG  = 3;

   typedef struct {
      int kind;
      int cyc;
      int tog;
      int md;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       btn_level;
   logic       press_pulse;
   logic       long_pulse;
   logic       toggle_out;
   logic [1:0] mode;

   ev_t exp_q[$];
   int  cyc       = 0;
   int  chk_cnt   = 0;
   int  err_cnt   = 0;
   int  exp_tog   = 0;
   int  exp_mode  = 0;
   logic prev_level = 1'b0;

   button_conditioner #(
      .CLK_HZ        (1000),
      .DEBOUNCE_MS   (4),
      .LONG_PRESS_MS (20),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk_20Mhz   (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .press_pulse (press_pulse),
      .long_pulse  (long_pulse),
      .toggle_out  (toggle_out),
      .mode        (mode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      e.tog  = exp_tog;
      e.md   = exp_mode;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         check_val("unexpected_event", kind, -1);
      end else begin
         e = exp_q.pop_front();
         check_val("event_kind", kind, e.kind);
         check_val("event_cycle", cyc, e.cyc);
         check_val("event_toggle", int'(toggle_out), e.tog);
         check_val("event_mode", int'(mode), e.md);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("drain", exp_q.size(), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_level"}, int'(btn_level), 0);
      check_val({tag, "_press"}, int'(press_pulse), 0);
      check_val({tag, "_long"}, int'(long_pulse), 0);
      check_val({tag, "_toggle"}, int'(toggle_out), 0);
      check_val({tag, "_mode"}, int'(mode), 0);
      check_val({tag, "_state"}, int'(dut.state_q), int'(ST_RELEASED));
   endtask

   // Press for 'hold' cycles (pin low), then release; hold 10 = short, 30 = long.
   task automatic press_hold(input int hold);
      int c, p, r;
      @(negedge clk);
      btn_in = 1'b0;
      c = cyc;
      p = c + 3 + DB;
      r = c + hold;
      push_ev(EV_RISE, p);
      if (r + 3 > p + LONG) begin
         exp_mode = (exp_mode + 1) % 4;
         push_ev(EV_LONG, p + LONG);
         push_ev(EV_FALL, r + 3 + DB);
      end else begin
         exp_tog = exp_tog ^ 1;
         push_ev(EV_FALL, r + 3 + DB);
         push_ev(EV_PRESS, r + 3 + DB);
      end
      repeat (hold) @(negedge clk);
      btn_in = 1'b1;
      repeat (DB + 10) @(negedge clk);
      drain(40);
   endtask

   // Output monitor: level edges and every pulse-high cycle are events.
   always @(negedge clk) begin
      if (rst) begin
         prev_level = btn_level;
      end else begin
         if (btn_level && !prev_level) got_ev(EV_RISE);
         if (!btn_level && prev_level) got_ev(EV_FALL);
         if (press_pulse) got_ev(EV_PRESS);
         if (long_pulse) got_ev(EV_LONG);
         check_val("pulse_exclusive", int'(press_pulse & long_pulse), 0);
         prev_level = btn_level;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, r;
      rst    = 1'b1;
      btn_in = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Short press
      press_hold(10);

      // Bounce: 2 cycles low, 1 high, five times
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         btn_in = 1'b0;
         @(negedge clk);
         @(negedge clk);
         btn_in = 1'b1;
      end
      repeat (10) @(negedge clk);
      check_val("bounce_level", int'(btn_level), 0);
      check_val("bounce_state", int'(dut.state_q), int'(ST_RELEASED));
      drain(5);

      // Long press
      press_hold(30);

      // Release bounce during PRESSED, later long press delayed by 2 cycles
      @(negedge clk);
      btn_in = 1'b0;
      c = cyc;
      push_ev(EV_RISE, c + 3 + DB);
      exp_mode = (exp_mode + 1) % 4;
      push_ev(EV_LONG, c + 29);
      push_ev(EV_FALL, c + 47);
      repeat (12) @(negedge clk);
      btn_in = 1'b1;
      repeat (2) @(negedge clk);
      btn_in = 1'b0;
      repeat (26) @(negedge clk);
      btn_in = 1'b1;
      repeat (DB + 10) @(negedge clk);
      drain(40);

      // Clean reset clears toggle and mode
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_outputs_zero("reset2");
      @(negedge clk);
      #1 rst = 1'b0;
      exp_tog  = 0;
      exp_mode = 0;
      repeat (3) @(negedge clk);

      // Mode wrap and toggle sequence
      for (int i = 0; i < 4; i++) press_hold(30);
      check_val("mode_wrapped", int'(mode), 0);
      press_hold(10);
      press_hold(10);
      check_val("toggle_twice", int'(toggle_out), 0);
      press_hold(30);
      press_hold(10);

      // Reset mid-operation with hold_cnt at 10
      @(negedge clk);
      btn_in = 1'b0;
      c = cyc;
      push_ev(EV_RISE, c + 3 + DB);
      repeat (17) @(negedge clk);
      check_val("hold_cnt_before_rst", int'(dut.hold_cnt_q), 10);
      check_val("mode_before_rst", int'(mode), 1);
      #1 rst = 1'b1;
      #1 check_outputs_zero("mid_reset");
      check_val("mid_reset_queue", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      c = cyc;
      exp_tog  = 0;
      exp_mode = 0;
      push_ev(EV_RISE, c + 3 + DB);
      repeat (12) @(negedge clk);
      btn_in = 1'b1;
      r = cyc;
      exp_tog = 1;
      push_ev(EV_FALL, r + 3 + DB);
      push_ev(EV_PRESS, r + 3 + DB);
      repeat (DB + 10) @(negedge clk);
      drain(40);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
